// File: rtl/fx2_slave_fifo_writer.sv
// fx2_slave_fifo_writer
//   Sink stage between the capture CDC FIFO read side and the FX2 slave-FIFO bus,
//   running on the FX2 interface clock. Pops 16-bit words with valid/ready and
//   writes them to the FX2 endpoint while it is not full. Words are counted per
//   USB packet; a partial packet is committed with pktend_o on an idle timeout or
//   on a flush request. In test mode a xorshift stream replaces capture data.
//
// Ports
//   clk_i        FX2 interface clock (IFCLK)
//   reset_i      asynchronous reset, active-high
//   data_i       word from CDC FIFO
//   valid_i      data_i valid
//   ready_o      pop strobe to CDC FIFO (transfer = valid_i && ready_o)
//   fifo_full_i  FX2 endpoint full flag, 1 = no write allowed
//   flush_i      single-cycle request to commit the current packet (ZLP if empty)
//   test_i       1 = emit test pattern instead of data_i (already synchronised)
//   slwr_o       FX2 write strobe, active-high, one cycle per word
//   pktend_o     FX2 packet-end strobe, active-high
//   fd_o         FX2 data bus, holds the last written word
//   pkt_cnt_o    committed-packet count (full + short), wraps at 2^16
//
// States
//   S_DATA   | forward capture words; decide test entry or packet commit
//   S_GAP    | one dead cycle so pktend never follows a write directly
//   S_PKTEND | wait for endpoint space, then strobe pktend_o
//   S_TEST   | write xorshift pattern words
module fx2_slave_fifo_writer #(
  parameter int          PKT_WORDS = 256,
  parameter int          TIMEOUT   = 4096,
  parameter logic [15:0] SEED      = 16'h6c41
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        fifo_full_i,
  input  logic        flush_i,
  input  logic        test_i,
  output logic        slwr_o,
  output logic        pktend_o,
  output logic [15:0] fd_o,
  output logic [15:0] pkt_cnt_o
);

  localparam int WCW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int IDW = $clog2(TIMEOUT);
  localparam logic [WCW-1:0] WC_LAST   = WCW'(PKT_WORDS - 1);
  localparam logic [IDW-1:0] IDLE_LOAD = IDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_DATA, S_GAP, S_PKTEND, S_TEST} state_t;

  state_t         state, state_nx;
  logic [WCW-1:0] wcnt;
  logic [IDW-1:0] idle_left;
  logic           flush_pend;
  logic [15:0]    rng, rng_nx;
  logic           idle_tc, commit_req;
  logic           wr_data, wr_test, wr, end_pkt, rng_seed;

  function automatic logic [15:0] xs_next(input logic [15:0] s);
    logic [15:0] t;
    t = s ^ (s << 7);
    t = t ^ (t >> 9);
    return t ^ (t << 8);
  endfunction

  // Idle timer counts down from TIMEOUT-1; reaching zero is the same moment an
  // up-counter would hit TIMEOUT-1. It saturates at zero.
  assign idle_tc    = (idle_left == '0);
  assign commit_req = flush_pend || (idle_tc && (wcnt != '0));
  assign rng_nx     = xs_next(rng);

  // Gated with reset so the pop strobe is low while the block is held in reset.
  assign ready_o = !reset_i && (state == S_DATA) && !test_i && !fifo_full_i && !commit_req;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= S_DATA;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr_data  = 1'b0;
    wr_test  = 1'b0;
    end_pkt  = 1'b0;
    rng_seed = 1'b0;
    unique case (state)
      S_DATA: begin
        if (test_i) begin
          if (wcnt != '0) begin
            state_nx = S_GAP;
          end else begin
            state_nx = S_TEST;
            rng_seed = 1'b1;
          end
        end else if (commit_req) begin
          state_nx = S_GAP;
        end else begin
          wr_data = valid_i && ready_o;
        end
      end
      S_GAP: state_nx = S_PKTEND;
      S_PKTEND: begin
        if (!fifo_full_i) begin
          end_pkt  = 1'b1;
          state_nx = S_DATA;
        end
      end
      S_TEST: begin
        if (!test_i)           state_nx = (wcnt != '0) ? S_GAP : S_DATA;
        else if (!fifo_full_i) wr_test  = 1'b1;
      end
      default: state_nx = S_DATA;
    endcase
  end

  assign wr = wr_data || wr_test;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      slwr_o     <= 1'b0;
      pktend_o   <= 1'b0;
      fd_o       <= '0;
      pkt_cnt_o  <= '0;
      wcnt       <= '0;
      idle_left  <= IDLE_LOAD;
      flush_pend <= 1'b0;
      rng        <= SEED;
    end else begin
      slwr_o   <= wr;
      pktend_o <= end_pkt;

      if (wr_data)      fd_o <= data_i;
      else if (wr_test) fd_o <= rng_nx;

      if (rng_seed)     rng <= SEED;
      else if (wr_test) rng <= rng_nx;

      // A full packet is committed by the FX2 itself, so only the count moves.
      if (end_pkt)  wcnt <= '0;
      else if (wr)  wcnt <= (wcnt == WC_LAST) ? '0 : wcnt + 1'b1;

      if (end_pkt || (wr && (wcnt == WC_LAST))) pkt_cnt_o <= pkt_cnt_o + 16'd1;

      if (end_pkt || wr || (wcnt == '0)) idle_left <= IDLE_LOAD;
      else if (!idle_tc)                 idle_left <= idle_left - 1'b1;

      // A flush arriving while one is already pending (or being issued) is absorbed.
      if (end_pkt)      flush_pend <= 1'b0;
      else if (flush_i) flush_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fx2_slave_fifo_writer.sv
module tb_fx2_slave_fifo_writer;
  localparam int          PKT_WORDS = 256;
  localparam int          TIMEOUT   = 4096;
  localparam logic [15:0] SEED      = 16'h6c41;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [15:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        fifo_full_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        test_i = 1'b0;
  logic        ready_o, slwr_o, pktend_o;
  logic [15:0] fd_o, pkt_cnt_o;

  fx2_slave_fifo_writer #(.PKT_WORDS(PKT_WORDS), .TIMEOUT(TIMEOUT), .SEED(SEED)) dut (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .fifo_full_i(fifo_full_i), .flush_i(flush_i), .test_i(test_i), .slwr_o(slwr_o),
    .pktend_o(pktend_o), .fd_o(fd_o), .pkt_cnt_o(pkt_cnt_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int full_mode = 0;
  int tcnt = 0;

  // reference model: words in the open packet, quiet-period start, pending flush,
  // commit progress (0 none, 1 dead cycle, 2 waiting for space), pattern mode
  int          m_wcnt = 0;
  int          quiet_since = 0;
  int          closing = 0;
  bit          m_flush = 0;
  bit          pattern = 0;
  logic [15:0] m_rng = SEED;
  bit          e_slwr = 0, e_pktend = 0;
  logic [15:0] e_fd = '0, e_pkt = '0;

  bit          prev_full = 0, prev_slwr = 0;
  int          n_slwr = 0, n_pktend = 0, last_slwr_cyc = 0, last_gap = 0;
  logic [15:0] wr_log[$];

  int idle_now;
  bit commit, exp_ready, wrote, end_now;

  function automatic logic [15:0] xs16(input logic [15:0] s);
    logic [15:0] t;
    t = s ^ (s << 7);
    t = t ^ (t >> 9);
    return t ^ (t << 8);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset_i) begin
      chk("rst_slwr",   32'(slwr_o),    32'd0);
      chk("rst_pktend", 32'(pktend_o),  32'd0);
      chk("rst_fd",     32'(fd_o),      32'd0);
      chk("rst_pkt",    32'(pkt_cnt_o), 32'd0);
      chk("rst_ready",  32'(ready_o),   32'd0);
      m_wcnt = 0; m_flush = 0; closing = 0; pattern = 0; m_rng = SEED; quiet_since = cyc;
      e_slwr = 0; e_pktend = 0; e_fd = '0; e_pkt = '0;
    end else begin
      if (slwr_o) begin
        n_slwr++; last_slwr_cyc = cyc; wr_log.push_back(fd_o);
        chk("slwr_after_full", 32'(prev_full), 32'd0);
      end
      if (pktend_o) begin
        n_pktend++; last_gap = cyc - last_slwr_cyc;
        chk("pktend_next_to_slwr", 32'(slwr_o | prev_slwr), 32'd0);
        chk("pktend_while_full", 32'(prev_full), 32'd0);
      end

      idle_now  = cyc - quiet_since;
      commit    = m_flush || (m_wcnt != 0 && idle_now >= TIMEOUT - 1);
      exp_ready = (closing == 0) && !pattern && !test_i && !fifo_full_i && !commit;
      chk("ready",  32'(ready_o),   32'(exp_ready));
      chk("slwr",   32'(slwr_o),    32'(e_slwr));
      chk("pktend", 32'(pktend_o),  32'(e_pktend));
      chk("fd",     32'(fd_o),      32'(e_fd));
      chk("pkt_cnt",32'(pkt_cnt_o), 32'(e_pkt));

      wrote = 0; end_now = 0;
      if (closing == 1) closing = 2;
      else if (closing == 2) end_now = !fifo_full_i;
      else if (pattern) begin
        if (!test_i) begin
          pattern = 0;
          if (m_wcnt != 0) closing = 1;
        end else if (!fifo_full_i) begin
          wrote = 1; m_rng = xs16(m_rng); e_fd = m_rng;
        end
      end else if (test_i) begin
        if (m_wcnt != 0) closing = 1;
        else begin pattern = 1; m_rng = SEED; end
      end else if (commit) closing = 1;
      else if (valid_i && exp_ready) begin
        wrote = 1; e_fd = data_i;
      end

      if (wrote || m_wcnt == 0) quiet_since = cyc + 1;
      e_slwr = wrote; e_pktend = end_now;
      if (wrote) begin
        m_wcnt++;
        if (m_wcnt == PKT_WORDS) begin m_wcnt = 0; e_pkt = e_pkt + 16'd1; end
      end
      if (end_now) begin
        closing = 0; m_wcnt = 0; m_flush = 0; quiet_since = cyc + 1; e_pkt = e_pkt + 16'd1;
      end else if (flush_i) m_flush = 1;
    end
    prev_full = fifo_full_i;
    prev_slwr = slwr_o;
    cyc++;
  end

  task automatic step(output bit took);
    @(negedge clk);
    took = valid_i && ready_o;
    @(posedge clk);
    #1;
    tcnt++;
    case (full_mode)
      1:       fifo_full_i = ((tcnt % 8) < 3);
      2:       fifo_full_i = ($urandom_range(3) == 0);
      default: fifo_full_i = 1'b0;
    endcase
  endtask

  task automatic feed(input int n);
    int sent = 0;
    int guard = 0;
    bit took;
    valid_i = 1'b1;
    data_i = 16'($urandom);
    while (sent < n && guard < n * 10 + 100) begin
      step(took);
      guard++;
      if (took) begin sent++; data_i = 16'($urandom); end
    end
    valid_i = 1'b0;
    chk("feed_words_accepted", 32'(sent), 32'(n));
  endtask

  task automatic wait_pktend(input int budget);
    int p0 = n_pktend;
    int i = 0;
    bit took;
    while (n_pktend == p0 && i < budget) begin step(took); i++; end
    chk("pktend_seen", 32'(n_pktend > p0), 32'd1);
  endtask

  task automatic apply_reset();
    bit took;
    valid_i = 0; flush_i = 0; test_i = 0; full_mode = 0; fifo_full_i = 0;
    #1 reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset_i = 1'b0;
    step(took);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached, bench should have finished earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit took;
    int s0, p0, g;

    // 1: 600 words straight through -> two auto-committed packets, 88 left open
    apply_reset();
    s0 = n_slwr; p0 = n_pktend;
    feed(600);
    step(took);
    chk("t1_slwr_count", 32'(n_slwr - s0), 32'd600);
    chk("t1_pkt_cnt", 32'(pkt_cnt_o), 32'd2);
    chk("t1_model_wcnt", 32'(m_wcnt), 32'd88);
    chk("t1_no_pktend", 32'(n_pktend - p0), 32'd0);

    // 2: 10 words then idle -> short packet after the timeout
    apply_reset();
    feed(10);
    wait_pktend(TIMEOUT + 50);
    chk("t2_pkt_cnt", 32'(pkt_cnt_o), 32'd1);
    chk("t2_slwr_to_pktend", 32'(last_gap), 32'(TIMEOUT + 2));

    // 3: flush on empty -> one ZLP; repeated flush -> still one
    apply_reset();
    flush_i = 1; step(took); flush_i = 0;
    wait_pktend(20);
    chk("t3_zlp_pkt_cnt", 32'(pkt_cnt_o), 32'd1);
    p0 = n_pktend;
    flush_i = 1; repeat (3) step(took); flush_i = 0;
    repeat (20) step(took);
    chk("t3_double_flush_pktends", 32'(n_pktend - p0), 32'd1);
    chk("t3_pkt_cnt", 32'(pkt_cnt_o), 32'd2);

    // 4: endpoint full 3 on / 5 off under continuous traffic, then flush
    apply_reset();
    full_mode = 1;
    s0 = n_slwr;
    feed(300);
    flush_i = 1; step(took); flush_i = 0;
    wait_pktend(60);
    chk("t4_slwr_count", 32'(n_slwr - s0), 32'd300);
    chk("t4_pkt_cnt", 32'(pkt_cnt_o), 32'd2);
    full_mode = 0;

    // 5: test pattern from idle, full packet, then stop mid-packet
    apply_reset();
    wr_log.delete();
    test_i = 1;
    g = 0;
    while (wr_log.size() < 256 && g < 400) begin step(took); g++; end
    chk("t5_pkt_after_256", 32'(pkt_cnt_o), 32'd1);
    while (wr_log.size() < 261 && g < 400) begin step(took); g++; end
    test_i = 0;
    p0 = n_pktend;
    wait_pktend(50);
    repeat (5) step(took);
    chk("t5_first_word", (wr_log.size() > 0) ? 32'(wr_log[0]) : 32'hdead_beef, 32'h0000abe7);
    chk("t5_pktend_once", 32'(n_pktend - p0), 32'd1);
    chk("t5_pkt_cnt", 32'(pkt_cnt_o), 32'd2);

    // 6: asynchronous reset mid-packet, then one full packet
    apply_reset();
    valid_i = 1;
    feed(100);
    valid_i = 1;
    #2 reset_i = 1'b1;
    #1;
    chk("t6_async_slwr",   32'(slwr_o),    32'd0);
    chk("t6_async_fd",     32'(fd_o),      32'd0);
    chk("t6_async_pktend", 32'(pktend_o),  32'd0);
    chk("t6_async_pkt",    32'(pkt_cnt_o), 32'd0);
    chk("t6_async_ready",  32'(ready_o),   32'd0);
    valid_i = 0;
    @(posedge clk);
    #3 reset_i = 1'b0;
    p0 = n_pktend;
    feed(256);
    step(took);
    chk("t6_pkt_cnt", 32'(pkt_cnt_o), 32'd1);
    chk("t6_no_pktend", 32'(n_pktend - p0), 32'd0);

    // random traffic, backpressure, flushes and test-mode toggles
    apply_reset();
    full_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      valid_i = ($urandom_range(9) < 7);
      data_i  = 16'($urandom);
      flush_i = ($urandom_range(63) == 0);
      if ($urandom_range(149) == 0) test_i = ~test_i;
      step(took);
    end
    valid_i = 0; flush_i = 0; test_i = 0;
    repeat (3) step(took);
    flush_i = 1; step(took); flush_i = 0;
    wait_pktend(200);
    repeat (5) step(took);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
